serial_sub: RTL
===============

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter: WIDTH, default 6, operand and result width in bits (legal range 2..16).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; captured on the accepted start edge.
REQ-006 b  input  WIDTH  subtrahend; captured on the accepted start edge.
REQ-007 busy  output  1  high while an operation is in progress (SHIFT and DONE states).
REQ-008 done  output  1  single-cycle pulse marking a valid result.
REQ-009 diff  output  WIDTH  result (a - b) mod 2^WIDTH, two's-complement encoding.
REQ-010 borrow  output  1  high when unsigned a < b.
REQ-011 ovf  output  1  signed overflow flag (see Configuration).

Function
REQ-012 The block SHALL compute a - b bit-serially as a + ~b + 1, one bit per clock, LSB first.
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE, encoded in 2 bits.
REQ-014 IDLE: start=1 SHALL load a and b into shift registers, set carry to 1, clear the bit counter, and go to SHIFT; start=0 SHALL remain in IDLE.
REQ-015 SHIFT: each cycle SHALL form s = a_sr[0] ^ ~b_sr[0] ^ carry, shift s into the result register MSB, shift a_sr and b_sr right by one, and update carry to the majority of (a_sr[0], ~b_sr[0], carry).
REQ-016 SHIFT SHALL last exactly WIDTH cycles and then go to DONE.
REQ-017 DONE: the block SHALL assert done for exactly one cycle, update diff, borrow = ~carry, and ovf, and return to IDLE.
REQ-018 Latency: with start accepted at edge k, done SHALL be high in the cycle after edge k+WIDTH+1 (WIDTH+1 cycles for WIDTH=6: done after edge k+7).
REQ-019 diff, borrow and ovf SHALL hold their last values until the next DONE cycle; intermediate shift values SHALL NOT appear on diff.
REQ-020 start asserted while busy=1 SHALL be ignored, with no effect on state or outputs.
REQ-021 start held high continuously SHALL begin a new operation on the first IDLE cycle after DONE (back-to-back throughput: one result every WIDTH+2 cycles).
REQ-022 Changes on a and b after the accepted start edge SHALL NOT affect the result.
REQ-023 b=0 SHALL give diff=a and borrow=0; a=b SHALL give diff=0 and borrow=0.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, diff=0, borrow=0, ovf=0, carry=0, counter=0, and shift registers=0, independent of clk.
REQ-025 Reset asserted mid-operation SHALL abort the operation, and no done pulse SHALL follow.
REQ-026 After rst_n deasserts, the first rising edge SHALL be able to accept start.

Configuration
REQ-027 Macro SERIAL_SUB_OVF_EN: when defined, ovf SHALL be set at DONE to (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands.
REQ-028 When SERIAL_SUB_OVF_EN is not defined, ovf SHALL be tied to 0, and no overflow logic or operand-MSB storage SHALL be synthesised; all other behaviour SHALL be unchanged.

Verification
REQ-029 Use WIDTH=6. Apply a=0, b=6'b100111, start one cycle -> done pulses 7 cycles later; diff=6'b011001, borrow=1, ovf=0.
REQ-030 Apply a=5, b=3 -> diff=6'b000010, borrow=0, ovf=0; a=3, b=5 -> diff=6'b111110, borrow=1.
REQ-031 With the macro defined, apply a=6'b100000 (-32), b=1 -> diff=6'b011111, ovf=1; without the macro -> ovf=0 and the same diff.
REQ-032 Start a=9, b=4, then pulse start again with a=1, b=1 on cycle 3 -> second start ignored; single done with diff=5.
REQ-033 Drop rst_n on cycle 4 of an operation -> all outputs 0 immediately, no done pulse; a fresh a=7, b=7 operation -> diff=0, borrow=0.
REQ-034 Hold start high with a=10, b=2 -> done pulses every 8 cycles, each with diff=8.

Source files
------------

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial two's-complement subtractor (a - b), LSB first
//
// Computes diff = (a - b) mod 2^WIDTH as a + ~b + 1, one bit per clock.
// Optional feature macro: SERIAL_SUB_OVF_EN (signed overflow flag on ovf).
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - begin a subtraction (sampled only while idle)
//   a, b   - minuend / subtrahend, captured on the accepted start edge
//   busy   - high while an operation is in progress (SHIFT and DONE states)
//   done   - one-cycle pulse marking a valid result
//   diff   - result (a - b) mod 2^WIDTH
//   borrow - high when unsigned a < b
//   ovf    - signed overflow (0 when SERIAL_SUB_OVF_EN is not defined)

module serial_sub #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    count;
    logic             last_bit;
    logic             b_inv;
    logic             sum_bit;
    logic             carry_nxt;

    // Full adder on a + ~b with the carry seeded to 1 at start.
    assign b_inv     = ~b_sr[0];
    assign sum_bit   = a_sr[0] ^ b_inv ^ carry;
    assign carry_nxt = (a_sr[0] & b_inv) | (a_sr[0] & carry) | (b_inv & carry);
    assign last_bit  = (count == CW'(WIDTH - 1));

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath. diff/borrow/ovf are only written in DONE so the partial
    // result in res_sr never shows on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            count  <= '0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= 1'b1;
                        count <= '0;
                    end
                end
                SHIFT: begin
                    res_sr <= {sum_bit, res_sr[WIDTH-1:1]};
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    carry  <= carry_nxt;
                    count  <= count + CW'(1);
                end
                DONE: begin
                    done   <= 1'b1;
                    diff   <= res_sr;
                    // No carry out of a + ~b + 1 means the subtraction borrowed.
                    borrow <= ~carry;
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are kept separately because a_sr/b_sr are consumed
    // by the shift.
    logic a_msb;
    logic b_msb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
            end
            if (state == DONE) begin
                ovf <= (a_msb != b_msb) && (res_sr[WIDTH-1] != a_msb);
            end
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule
